// File: rtl/bcd_cascade_counter_pkg.sv
// Shared constants and helpers for the cascaded BCD counter.
// Holds the digit width, the decimal modulus, the direction encoding and the per-digit arithmetic.
package bcd_cascade_counter_pkg;

  localparam int BCD_W   = 4;
  localparam int DEC_MOD = 10;

  typedef enum logic {
    DOWN = 1'b0,
    UP   = 1'b1
  } dir_e;

  // Loaded digits that are out of range for their modulus are replaced by zero.
  function automatic logic [BCD_W-1:0] digit_sanitize(input logic [BCD_W-1:0] d,
                                                      input int modulus);
    logic [BCD_W-1:0] res;
    res = d;
    if (d >= BCD_W'(modulus)) begin
      res = '0;
    end
    return res;
  endfunction

  function automatic logic [BCD_W-1:0] digit_step(input logic [BCD_W-1:0] cur,
                                                  input dir_e dir,
                                                  input int modulus);
    logic [BCD_W-1:0] res;
    res = cur;
    if (dir == UP) begin
      res = (cur == BCD_W'(modulus - 1)) ? '0 : cur + BCD_W'(1);
    end else begin
      res = (cur == '0) ? BCD_W'(modulus - 1) : cur - BCD_W'(1);
    end
    return res;
  endfunction

endpackage

// File: rtl/bcd_cascade_counter_digit.sv
// One BCD digit with programmable modulus: synchronous reset, load, and up/down step.
// Exposes at_max/at_zero so the parent can build the ripple-free step enables.
module bcd_digit
  import bcd_cascade_counter_pkg::*;
#(
  parameter int MODULUS = DEC_MOD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             step,
  input  logic             up_dn,
  input  logic             load,
  input  logic [BCD_W-1:0] d,
  output logic [BCD_W-1:0] q,
  output logic             at_max,
  output logic             at_zero
);

  localparam logic [BCD_W-1:0] MAX_VAL = BCD_W'(MODULUS - 1);

  logic [BCD_W-1:0] q_q;
  logic [BCD_W-1:0] q_d;

  // Load beats step; reset beats both in the register below.
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = digit_sanitize(d, MODULUS);
    end else if (step) begin
      q_d = digit_step(q_q, dir_e'(up_dn), MODULUS);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q       = q_q;
  assign at_max  = (q_q == MAX_VAL);
  assign at_zero = (q_q == '0);

endmodule

// File: rtl/bcd_cascade_counter.sv
// Cascaded up/down BCD counter built from NUM_DIGITS bcd_digit instances.
// The top digit uses MSD_MODULUS; carry_out flags the wrapping cycle for direct cascading.
module bcd_cascade_counter
  import bcd_cascade_counter_pkg::*;
#(
  parameter int NUM_DIGITS  = 2,
  parameter int MSD_MODULUS = 6
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        up_dn,
  input  logic                        load,
  input  logic [BCD_W*NUM_DIGITS-1:0] load_val,
  output logic [BCD_W*NUM_DIGITS-1:0] count,
  output logic                        carry_out
);

  logic [NUM_DIGITS-1:0] at_max;
  logic [NUM_DIGITS-1:0] at_zero;
  logic [NUM_DIGITS-1:0] step;

  // low_*[i] is true when every digit below i sits at its terminal value.
  logic [NUM_DIGITS:0]   low_max;
  logic [NUM_DIGITS:0]   low_zero;
  logic                  terminal;

  assign low_max[0]  = 1'b1;
  assign low_zero[0] = 1'b1;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
    localparam int DIG_MOD = (i == NUM_DIGITS - 1) ? MSD_MODULUS : DEC_MOD;

    assign low_max[i+1]  = low_max[i] & at_max[i];
    assign low_zero[i+1] = low_zero[i] & at_zero[i];
    assign step[i]       = en & ((dir_e'(up_dn) == UP) ? low_max[i] : low_zero[i]);

    bcd_digit #(
      .MODULUS (DIG_MOD)
    ) u_digit (
      .clk     (clk),
      .rst     (rst),
      .step    (step[i]),
      .up_dn   (up_dn),
      .load    (load),
      .d       (load_val[BCD_W*i +: BCD_W]),
      .q       (count[BCD_W*i +: BCD_W]),
      .at_max  (at_max[i]),
      .at_zero (at_zero[i])
    );
  end

  assign terminal  = (dir_e'(up_dn) == UP) ? low_max[NUM_DIGITS] : low_zero[NUM_DIGITS];
  assign carry_out = en & ~load & ~rst & terminal;

endmodule

// File: tb/tb_bcd_cascade_counter.sv
// Directed and randomized checks of bcd_cascade_counter against an integer-valued model.
// Two instances: default (2 digits, mod-6 MSD) and 3 decimal digits.
module tb_bcd_cascade_counter;

  localparam int N2 = 2;
  localparam int M2 = 6;
  localparam int N3 = 3;
  localparam int M3 = 10;

  logic        clk;
  logic        rst;
  logic        en2, up2, ld2;
  logic [7:0]  lv2;
  logic [7:0]  cnt2;
  logic        co2;
  logic        en3, up3, ld3;
  logic [11:0] lv3;
  logic [11:0] cnt3;
  logic        co3;

  int checks = 0;
  int errors = 0;
  int v2 = 0;
  int v3 = 0;

  bcd_cascade_counter #(.NUM_DIGITS(N2), .MSD_MODULUS(M2)) dut (
    .clk(clk), .rst(rst), .en(en2), .up_dn(up2), .load(ld2),
    .load_val(lv2), .count(cnt2), .carry_out(co2)
  );

  bcd_cascade_counter #(.NUM_DIGITS(N3), .MSD_MODULUS(M3)) dut3 (
    .clk(clk), .rst(rst), .en(en3), .up_dn(up3), .load(ld3),
    .load_val(lv3), .count(cnt3), .carry_out(co3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int pow10(input int e);
    int p = 1;
    for (int k = 0; k < e; k++) p = p * 10;
    return p;
  endfunction

  function automatic int total(input int nd, input int msd);
    return msd * pow10(nd - 1);
  endfunction

  function automatic logic [31:0] to_bcd(input int v, input int nd);
    logic [31:0] r = '0;
    for (int k = 0; k < nd; k++) r[4*k +: 4] = 4'((v / pow10(k)) % 10);
    return r;
  endfunction

  function automatic int from_load(input logic [31:0] lv, input int nd, input int msd);
    int v = 0;
    int d;
    int m;
    for (int k = 0; k < nd; k++) begin
      d = int'(lv[4*k +: 4]);
      m = (k == nd - 1) ? msd : 10;
      if (d >= m) d = 0;
      v = v + d * pow10(k);
    end
    return v;
  endfunction

  function automatic bit legal(input logic [31:0] c, input int nd, input int msd);
    bit ok = 1'b1;
    for (int k = 0; k < nd; k++) begin
      if (int'(c[4*k +: 4]) >= ((k == nd - 1) ? msd : 10)) ok = 1'b0;
    end
    return ok;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive the selected instance, check carry before the edge, count after it.
  task automatic tick(input string tag, input int sel, input bit r, input bit e,
                      input bit u, input bit l, input logic [31:0] lv);
    int tot;
    bit term;
    @(negedge clk);
    rst = r;
    en2 = 1'b0; ld2 = 1'b0; en3 = 1'b0; ld3 = 1'b0;
    if (sel == 2) begin
      en2 = e; up2 = u; ld2 = l; lv2 = lv[7:0];
    end else begin
      en3 = e; up3 = u; ld3 = l; lv3 = lv[11:0];
    end
    #1;
    if (sel == 2) begin
      tot  = total(N2, M2);
      term = u ? (v2 == tot - 1) : (v2 == 0);
      chk({tag, ".carry"}, {31'd0, co2}, {31'd0, e & ~l & ~r & term});
    end else begin
      tot  = total(N3, M3);
      term = u ? (v3 == tot - 1) : (v3 == 0);
      chk({tag, ".carry"}, {31'd0, co3}, {31'd0, e & ~l & ~r & term});
    end
    @(posedge clk);
    if (r) begin
      v2 = 0;
      v3 = 0;
    end else if (sel == 2) begin
      if (l) v2 = from_load(lv, N2, M2);
      else if (e) v2 = u ? (v2 + 1) % tot : (v2 + tot - 1) % tot;
    end else begin
      if (l) v3 = from_load(lv, N3, M3);
      else if (e) v3 = u ? (v3 + 1) % tot : (v3 + tot - 1) % tot;
    end
    #1;
    chk({tag, ".count2"}, {24'd0, cnt2}, to_bcd(v2, N2));
    chk({tag, ".count3"}, {20'd0, cnt3}, to_bcd(v3, N3));
  endtask

  initial begin
    bit e, u, l, r;
    logic [31:0] lv;
    rst = 1'b1;
    en2 = 1'b0; up2 = 1'b1; ld2 = 1'b0; lv2 = '0;
    en3 = 1'b0; up3 = 1'b1; ld3 = 1'b0; lv3 = '0;

    // Reset overrides a simultaneous load and enable, carry held low.
    tick("reset", 2, 1, 1, 1, 1, 32'h47);
    chk("reset.literal", {24'd0, cnt2}, 32'h00);

    for (int i = 0; i < 60; i++) tick("up_run", 2, 0, 1, 1, 0, 0);
    chk("up_run.wrapped", {24'd0, cnt2}, 32'h00);

    tick("load_3A", 2, 0, 0, 1, 1, 32'h3A);
    chk("load_3A.literal", {24'd0, cnt2}, 32'h30);
    tick("load_75", 2, 0, 1, 0, 1, 32'h75);
    chk("load_75.literal", {24'd0, cnt2}, 32'h05);

    tick("load_00", 2, 0, 0, 1, 1, 32'h00);
    tick("down_wrap", 2, 0, 1, 0, 0, 0);
    chk("down_wrap.literal", {24'd0, cnt2}, 32'h59);
    tick("down_58", 2, 0, 1, 0, 0, 0);
    chk("down_58.literal", {24'd0, cnt2}, 32'h58);
    tick("dir_up", 2, 0, 1, 1, 0, 0);
    tick("dir_down", 2, 0, 1, 0, 0, 0);
    tick("hold", 2, 0, 0, 1, 0, 0);

    tick("load_47", 2, 0, 0, 1, 1, 32'h47);
    tick("load_wins", 2, 0, 1, 1, 1, 32'h12);
    chk("load_wins.literal", {24'd0, cnt2}, 32'h12);
    tick("rst_over_load", 2, 1, 1, 1, 1, 32'h33);
    chk("rst_over_load.literal", {24'd0, cnt2}, 32'h00);

    tick("d3_load_099", 3, 0, 0, 1, 1, 32'h099);
    tick("d3_up_100", 3, 0, 1, 1, 0, 0);
    chk("d3_up_100.literal", {20'd0, cnt3}, 32'h100);
    tick("d3_load_999", 3, 0, 0, 1, 1, 32'h999);
    tick("d3_wrap", 3, 0, 1, 1, 0, 0);
    chk("d3_wrap.literal", {20'd0, cnt3}, 32'h000);
    tick("d3_down_wrap", 3, 0, 1, 0, 0, 0);
    chk("d3_down_wrap.literal", {20'd0, cnt3}, 32'h999);
    tick("d3_load_bad", 3, 0, 0, 1, 1, 32'hAFB);

    for (int i = 0; i < 1000; i++) begin
      e  = 1'($urandom_range(1, 0));
      u  = 1'($urandom_range(1, 0));
      l  = ($urandom_range(15, 0) == 0);
      r  = ($urandom_range(63, 0) == 0);
      lv = $urandom;
      tick("rand2", 2, r, e, u, l, lv);
      chk("rand2.legal", {31'd0, legal({24'd0, cnt2}, N2, M2)}, 32'd1);
    end

    for (int i = 0; i < 400; i++) begin
      e  = ($urandom_range(3, 0) != 0);
      u  = 1'($urandom_range(1, 0));
      l  = ($urandom_range(31, 0) == 0);
      lv = $urandom;
      tick("rand3", 3, 0, e, u, l, lv);
      chk("rand3.legal", {31'd0, legal({20'd0, cnt3}, N3, M3)}, 32'd1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
